// File: rtl/mux_arb2_pkg.sv
// Shared types and constants for the mux_arb2 round-robin arbiter.
package mux_arb2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Round-robin pick: a tie goes to the channel that did not win last.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last_ch);
    if (r0 && r1) begin
      return !last_ch;
    end
    return r1 ? CH1 : CH0;
  endfunction

endpackage

// File: rtl/mux_arb2_hold_counter.sv
// Grant-length counter; expired flags the final permitted grant cycle.
module hold_counter
  import mux_arb2_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sat,
  output logic expired
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(HOLD_CYCLES - 1));

  // Saturation parks the count on the expiry value while a lock holds the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(sat && expired)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux_arb2.sv
// Two-requester round-robin arbiter driving a mux2to1 select line.
// Optional grant extension via `lock` when MUX_ARB2_LOCK_EN is defined.
module mux_arb2
  import mux_arb2_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
`ifdef MUX_ARB2_LOCK_EN
  input  logic lock,
`endif
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy
);

  state_t state, next_state;
  logic   last, last_d;
  logic   gnt0_d, gnt1_d, sel_d;
  logic   cnt_clr, cnt_en, expired;
  logic   lock_i;
  logic   owner_req;
  logic   winner;

`ifdef MUX_ARB2_LOCK_EN
  assign lock_i = lock;
`else
  assign lock_i = 1'b0;
`endif

  hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .sat    (lock_i),
    .expired(expired)
  );

  assign winner    = pick_winner(req0, req1, last);
  assign owner_req = sel ? req1 : req0;

  // Next-state and next-output logic.
  always_comb begin
    next_state = state;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    sel_d      = sel;
    last_d     = last;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (state)
      IDLE, TURN: begin
        if (req0 || req1) begin
          next_state = GRANT;
          gnt0_d     = (winner == CH0);
          gnt1_d     = (winner == CH1);
          sel_d      = winner;
          last_d     = winner;
          cnt_clr    = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      GRANT: begin
        cnt_en = 1'b1;
        if (!owner_req || (expired && !lock_i)) begin
          next_state = TURN;
        end else begin
          gnt0_d = gnt0;
          gnt1_d = gnt1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      sel   <= CH0;
      last  <= CH1;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      gnt0  <= gnt0_d;
      gnt1  <= gnt1_d;
      sel   <= sel_d;
      last  <= last_d;
      busy  <= (next_state != IDLE);
    end
  end

endmodule

// File: doc/mux_arb2.md
# mux_arb2

Two-requester round-robin arbiter that drives the select line of the `mux2to1` datapath stage directly downstream of it. Each requester raises a request. The arbiter grants one requester at a time for a bounded number of cycles and holds `sel` stable for the whole grant. A one-cycle turnaround separates consecutive grants so the mux output settles before ownership changes.

## Interface
- `HOLD_CYCLES`, default 4: maximum grant length in cycles; legal range 1..255.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `req0` input, 1 bit: request from channel 0, the mux `a` input. Held high until granted and serviced.
- `req1` input, 1 bit: request from channel 1, the mux `b` input.
- `lock` input, 1 bit: extends the current grant. Present only with `MUX_ARB2_LOCK_EN`.
- `gnt0` output, 1 bit: grant to channel 0, registered.
- `gnt1` output, 1 bit: grant to channel 1, registered.
- `sel` output, 1 bit: drives mux `s`. 0 selects `a` (channel 0); 1 selects `b` (channel 1). Registered.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one channel owns the mux.
  - TURN: one dead cycle after every grant.
- Internal registers:
  - `last`: the most recent winner.
  - `cnt`: grant cycle counter, width `$clog2(HOLD_CYCLES+1)`.
- Reset values: state IDLE, `gnt0`=0, `gnt1`=0, `sel`=0, `busy`=0, `cnt`=0, `last`=1 (so channel 0 wins the first tie).
- Arbitration decision, made in IDLE and TURN from the sampled `req0`/`req1`:
  - Neither request: go to IDLE.
  - Exactly one request: grant that channel.
  - Both requests: grant `!last`.
- On a grant to channel n:
  - `gntn`=1 and `sel`=n, both updated on the same edge.
  - `last`=n, `cnt`=0.
  - Go to GRANT.
- GRANT:
  - `cnt` increments each cycle.
  - Release when the owner's request is sampled low, or when `cnt`==HOLD_CYCLES-1, whichever occurs first.
  - On release: both grants go to 0 and the state goes to TURN.
- TURN:
  - Grants stay low and `sel` holds its last value.
  - The arbitration decision is made this cycle, so the next grant asserts on the following edge.
- The owner holding its request across expiry, with the other channel idle, is re-granted after TURN with a fresh count.
- Invariants:
  - `gnt0` and `gnt1` are never high together.
  - `sel` changes only on an edge where a grant is asserted.
- `HOLD_CYCLES`=1: every grant lasts exactly 1 cycle and is followed by TURN.
- Reset mid-grant: on the next edge all outputs return to their reset values, regardless of state or counter.

## Timing
- Latency from IDLE: request sampled at edge k gives grant high from edge k+1.
- Maximum grant length: HOLD_CYCLES cycles.
- Dropping the request while granted: grant low on the next edge.
- Gap between consecutive grants: exactly 1 cycle (TURN).
- Worst-case wait with both channels requesting continuously: HOLD_CYCLES+1 cycles.
- All outputs are registered; no combinational path from input to output.

## Configuration
- Macro: `MUX_ARB2_LOCK_EN`.
- Defined:
  - The `lock` port exists.
  - While `lock` is sampled high in GRANT, the HOLD_CYCLES expiry is suppressed and `cnt` saturates at HOLD_CYCLES-1.
  - Release happens only when the owner's request drops, or at the first cycle after `lock` falls in which the expiry condition holds.
  - `lock` has no effect in IDLE or TURN.
- Undefined:
  - No `lock` port.
  - Behaviour is identical to `lock` tied to 0.

## Structure
- Shared package `mux_arb2_pkg`:
  - State encoding localparams: IDLE=2'd0, GRANT=2'd1, TURN=2'd2.
  - Channel constants: CH0=1'b0, CH1=1'b1.
- Sub-module `hold_counter`:
  - Ports: `clk`, `rst`, `clr`, `en`, `sat`.
  - Output: `expired`, parameterised by HOLD_CYCLES.
- Top level: the state machine plus output registers.

## Test plan
All scenarios use HOLD_CYCLES=4.
- Reset: `rst` high for 2 cycles with both requests high -> `gnt0`=`gnt1`=0, `sel`=0, `busy`=0. After `rst` falls, `gnt0`=1 one cycle later.
- Single requester: `req1` held high for 10 cycles ->
  - `gnt1` high for 4 cycles, low for 1, high for 4, low for 1.
  - `sel`=1 throughout.
- Contention: both requests held high ->
  - Grants alternate 0,1,0 in 4-cycle blocks, each followed by a 1-cycle gap.
  - `sel` toggles only on grant-rise edges.
  - No cycle has both grants high.
- Early release: `req0` high for 2 cycles after its grant, then low -> `gnt0` lasts 2 cycles, TURN follows, then IDLE with `busy`=0.
- Mid-grant reset: `rst` pulsed in the 3rd cycle of `gnt1` -> next edge gives `gnt1`=0, `sel`=0, and `last` reset so that channel 0 wins the next tie.
- Lock (`MUX_ARB2_LOCK_EN` defined): `lock` high with `req0` held for 7 grant cycles -> `gnt0` lasts 7 cycles even with `req1` high, then TURN, then `gnt1`.
